mux_sel_serializer: RTL and testbench

//   Parallel-in/serial-out stage that sits directly upstream of the 8x1 bit-select mux.

---
 rtl/mux_pkg.sv | 16 +
 rtl/bit_select_mux.sv | 24 ++
 rtl/mux_sel_serializer.sv | 114 +++++++++++
 tb/tb_mux_sel_serializer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the bit-select serializer slice.
//   state_t     : serializer control states (IDLE waits for a word, SHIFT streams its bits)
//   clog2_min1  : select-index width for an N-input mux, never narrower than one bit
package mux_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A one-input mux still needs a one-bit select port, so clamp at 1.
    function automatic int clog2_min1(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bit_select_mux.sv
// Combinational WIDTH-to-1 bit select.
//   data : word being serialized
//   sel  : bit index to present
//   y    : data[sel]
module bit_select_mux #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);

    // A single-input mux has nothing to select; this also avoids indexing a
    // one-bit vector with a select that is wider than it needs to be.
    generate
        if (WIDTH == 1) begin : g_single
            assign y = data[0];
        end else begin : g_multi
            assign y = data[sel];
        end
    endgenerate

endmodule

// File: rtl/mux_sel_serializer.sv
// Parallel-in / serial-out stage feeding an 8x1 bit-select mux.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : parallel word, taken when in_valid && in_ready
//   in_valid   : in_data is valid
//   in_ready   : stage can take a word this cycle
//   sel        : current bit index, exported to drive an external mux in lockstep
//   ser_out    : selected bit of the held word
//   ser_valid  : ser_out is valid
//   ser_ready  : downstream takes the bit when ser_valid && ser_ready
//   ser_last   : current bit is the final bit of the word
//   busy       : a word is in flight
module mux_sel_serializer
    import mux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = clog2_min1(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SEL_W-1:0] sel,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam logic [SEL_W-1:0] TOP_IDX   = SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] START_IDX = MSB_FIRST ? TOP_IDX : '0;
    localparam logic [SEL_W-1:0] END_IDX   = MSB_FIRST ? '0 : TOP_IDX;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             out_fire;
    logic             load;

    assign busy      = (state_q == SHIFT);
    assign ser_valid = busy;
    assign ser_last  = busy && (sel_q == END_IDX);
    assign sel       = sel_q;
    assign out_fire  = ser_valid && ser_ready;

    // Accepting during the final beat lets the next word start with no bubble;
    // this is the only path from an input (ser_ready) to an output.
    assign in_ready  = (state_q == IDLE) || (out_fire && ser_last);
    assign load      = in_valid && in_ready;

    bit_select_mux #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_mux (
        .data (data_q),
        .sel  (sel_q),
        .y    (ser_out)
    );

    // Next-state logic: a load (from IDLE, or on the last beat) always restarts
    // the index; otherwise each output handshake walks sel toward the end index
    // and the last handshake returns it to the start. With no handshake
    // everything holds, which keeps sel and ser_out stable through stalls.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    data_d  = in_data;
                    sel_d   = START_IDX;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (out_fire) begin
                    if (ser_last) begin
                        sel_d = START_IDX;
                        if (load) begin
                            data_d = in_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (MSB_FIRST) begin
                        sel_d = sel_q - SEL_W'(1);
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = START_IDX;
            end
        endcase
    end

    // State, word and index registers; reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= START_IDX;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_mux_sel_serializer.sv
// Self-checking bench for mux_sel_serializer: an LSB-first and an MSB-first
// instance share the same stimulus; each has its own queue of expected beats.
module tb_mux_sel_serializer;

    localparam int WIDTH = 8;

    typedef struct {
        logic       b;
        logic [2:0] idx;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] inData = '0;
    logic       inValid = 1'b0;
    logic       serReady = 1'b0;

    logic       inReadyL, serOutL, serValidL, serLastL, busyL;
    logic [2:0] selL;
    logic       inReadyM, serOutM, serValidM, serLastM, busyM;
    logic [2:0] selM;

    beat_t qL[$];
    beat_t qM[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_sel_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_ready(inReadyL),
        .sel(selL), .ser_out(serOutL), .ser_valid(serValidL), .ser_ready(serReady),
        .ser_last(serLastL), .busy(busyL)
    );

    mux_sel_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dutMsb (
        .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_ready(inReadyM),
        .sel(selM), .ser_out(serOutM), .ser_valid(serValidM), .ser_ready(serReady),
        .ser_last(serLastM), .busy(busyM)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a word is a list of WIDTH beats in transmission order.
    task automatic pushWord(input logic [7:0] w);
        beat_t b;
        for (int i = 0; i < WIDTH; i++) begin
            b.idx  = 3'(i);
            b.b    = w[i];
            b.last = (i == WIDTH - 1);
            qL.push_back(b);
            b.idx  = 3'(WIDTH - 1 - i);
            b.b    = w[WIDTH - 1 - i];
            qM.push_back(b);
        end
    endtask

    // Monitor: compares the DUT against the head of each queue, pops on a
    // handshake, and pushes a new word when the model says it is accepted.
    always @(negedge clk) begin
        logic inReadyExp;
        if (rst) begin
            qL.delete();
            qM.delete();
        end else begin
            inReadyExp = (qL.size() == 0) || (qL.size() == 1 && serReady);
            checkOutput("in_ready_lsb", 32'(inReadyL), 32'(inReadyExp));
            checkOutput("in_ready_msb", 32'(inReadyM), 32'(inReadyExp));
            checkOutput("busy_lsb", 32'(busyL), 32'(qL.size() != 0));
            checkOutput("busy_msb", 32'(busyM), 32'(qM.size() != 0));
            checkOutput("ser_valid_lsb", 32'(serValidL), 32'(qL.size() != 0));
            checkOutput("ser_valid_msb", 32'(serValidM), 32'(qM.size() != 0));
            if (qL.size() != 0) begin
                checkOutput("sel_lsb", 32'(selL), 32'(qL[0].idx));
                checkOutput("ser_out_lsb", 32'(serOutL), 32'(qL[0].b));
                checkOutput("ser_last_lsb", 32'(serLastL), 32'(qL[0].last));
            end else begin
                checkOutput("idle_sel_lsb", 32'(selL), 32'd0);
                checkOutput("idle_last_lsb", 32'(serLastL), 32'd0);
            end
            if (qM.size() != 0) begin
                checkOutput("sel_msb", 32'(selM), 32'(qM[0].idx));
                checkOutput("ser_out_msb", 32'(serOutM), 32'(qM[0].b));
                checkOutput("ser_last_msb", 32'(serLastM), 32'(qM[0].last));
            end else begin
                checkOutput("idle_sel_msb", 32'(selM), 32'd7);
                checkOutput("idle_last_msb", 32'(serLastM), 32'd0);
            end
            if (qL.size() != 0 && serReady) begin
                void'(qL.pop_front());
                void'(qM.pop_front());
            end
            if (inValid && inReadyExp) pushWord(inData);
        end
    end

    // Inputs change just after the rising edge and hold for one full cycle.
    task automatic applyStimulus(input logic [7:0] d, input logic v, input logic r);
        @(posedge clk);
        #1;
        inData   = d;
        inValid  = v;
        serReady = r;
    endtask

    task automatic waitIdle(input int maxCycles);
        int n = 0;
        applyStimulus(8'h00, 1'b0, 1'b1);
        while (qL.size() != 0 && n < maxCycles) begin
            applyStimulus(8'h00, 1'b0, 1'b1);
            n++;
        end
        applyStimulus(8'h00, 1'b0, 1'b1);
        checks++;
        if (qL.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: %0d beats left, expected 0", qL.size());
        end
    endtask

    initial begin
        int n;
        $display("[TB] start");
        repeat (3) applyStimulus(8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (2) applyStimulus(8'h00, 1'b0, 1'b0);

        // Single word, both bit orders, downstream always ready
        applyStimulus(8'b10110110, 1'b1, 1'b1);
        waitIdle(40);

        // Stall four cycles while sel sits at 3
        applyStimulus(8'b10110110, 1'b1, 1'b1);
        repeat (3) applyStimulus(8'h00, 1'b0, 1'b1);
        repeat (4) applyStimulus(8'h00, 1'b0, 1'b0);
        waitIdle(40);

        // Back-to-back words with in_valid held high
        applyStimulus(8'hA5, 1'b1, 1'b1);
        repeat (7) applyStimulus(8'h3C, 1'b1, 1'b1);
        applyStimulus(8'h3C, 1'b1, 1'b1);
        waitIdle(40);

        // Reset in the middle of a word
        applyStimulus(8'hFF, 1'b1, 1'b1);
        n = 0;
        applyStimulus(8'h00, 1'b0, 1'b1);
        while (qL.size() != 3 && n < 20) begin
            applyStimulus(8'h00, 1'b0, 1'b1);
            n++;
        end
        checkOutput("reached_sel5", 32'(qL.size()), 32'd3);
        rst = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b1);
        rst = 1'b0;
        applyStimulus(8'h01, 1'b1, 1'b1);
        waitIdle(40);

        // Requests during a word in flight are ignored
        applyStimulus(8'h0F, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(8'hF0, (i % 2 == 0), 1'b1);
        applyStimulus(8'hF0, 1'b0, 1'b1);
        waitIdle(40);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(8'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0));
        end
        waitIdle(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
